// File: rtl/sdram_ldr_pkg.sv
// sdram_ldr_pkg: shared types for the ROM download to SDRAM write path.
// Entry layout, byte-enable codes and the issue FSM encoding.
package sdram_ldr_pkg;

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] d;
  } ldr_entry_t;

  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_W  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } ldr_state_e;

  function automatic ldr_entry_t mk_entry(
    input logic [22:0] a,
    input logic [1:0]  ds,
    input logic [15:0] d
  );
    ldr_entry_t e;
    e.addr = a;
    e.ds   = ds;
    e.d    = d;
    return e;
  endfunction

endpackage

// File: rtl/sdram_rom_loader_if.sv
// sdram_rom_loader_if: general-purpose SDRAM request port.
// Toggle req/ack handshake with write address, byte enables and data.
interface sdram_rom_loader_if;
  logic        port_req;
  logic        port_ack;
  logic        port_we;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;

  modport master (
    output port_req, port_we, port_a, port_ds, port_d,
    input  port_ack
  );

  modport slave (
    input  port_req, port_we, port_a, port_ds, port_d,
    output port_ack
  );
endinterface

// File: rtl/ldr_fifo.sv
// ldr_fifo: small synchronous FIFO of packed write entries.
// First-word fall-through head, registered occupancy count.
module ldr_fifo
  import sdram_ldr_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ldr_entry_t din,
  input  logic       pop,
  output ldr_entry_t dout,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ldr_entry_t    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sdram_rom_loader.sv
// sdram_rom_loader: packs the byte-serial ROM download into 16-bit
// SDRAM writes and holds the core in reset until all are committed.
module sdram_rom_loader
  import sdram_ldr_pkg::*;
#(
  parameter int          FIFO_AW   = 2,
  parameter logic [22:0] BASE_ADDR = 23'h000000,
  parameter int          ADDR_W    = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_downl,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_ready,
  sdram_rom_loader_if.master sdr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] WAIT_TH = (FIFO_AW+1)'(DEPTH-1);
  localparam logic [0:0] ST_IDLE = S_IDLE;
  localparam logic [0:0] ST_WAIT = S_WAIT;

  logic [ADDR_W-2:0] waddr;
  logic [ADDR_W-2:0] pk_a, pk_a_n;
  logic [7:0]        pk_d, pk_d_n;
  logic              pk_v, pk_v_n;
  logic              pd_v, pd_v_n;
  ldr_entry_t        pd_e, pd_e_n;
  ldr_entry_t        push_e, head, lo_e;
  logic              push, pop;
  logic              f_full, f_empty;
  logic [FIFO_AW:0]  f_cnt, cnt_nxt;
  logic              wr_acc, odd, pair;
  logic              downl_q, wait_n;
  logic [0:0]        state;

  assign waddr  = ioctl_addr[ADDR_W-1:1];
  assign odd    = ioctl_addr[0];
  assign wr_acc = ioctl_wr && ioctl_downl && !ioctl_wait;
  assign pair   = pk_v && (pk_a == waddr);
  assign lo_e   = mk_entry(23'(pk_a), DS_LO, {8'h00, pk_d});
  assign pop    = (state == ST_IDLE) && !f_empty;

  assign sdr.port_we = 1'b1;

  // A queued second push always wins; it was announced via ioctl_wait.
  always_comb begin
    push   = 1'b0;
    push_e = '0;
    pk_v_n = pk_v;
    pk_a_n = pk_a;
    pk_d_n = pk_d;
    pd_v_n = pd_v;
    pd_e_n = pd_e;
    if (pd_v) begin
      if (!f_full) begin
        push   = 1'b1;
        push_e = pd_e;
        pd_v_n = 1'b0;
      end
    end else if (wr_acc) begin
      unique case (1'b1)
        !odd: begin
          push   = pk_v;
          push_e = lo_e;
          pk_v_n = 1'b1;
          pk_a_n = waddr;
          pk_d_n = ioctl_dout;
        end
        odd && pair: begin
          push   = 1'b1;
          push_e = mk_entry(23'(waddr), DS_W, {ioctl_dout, pk_d});
          pk_v_n = 1'b0;
        end
        odd && pk_v && !pair: begin
          push   = 1'b1;
          push_e = lo_e;
          pk_v_n = 1'b0;
          pd_v_n = 1'b1;
          pd_e_n = mk_entry(23'(waddr), DS_HI, {ioctl_dout, 8'h00});
        end
        default: begin
          push   = 1'b1;
          push_e = mk_entry(23'(waddr), DS_HI, {ioctl_dout, 8'h00});
        end
      endcase
    end else if (!ioctl_downl && pk_v && !f_full) begin
      push   = 1'b1;
      push_e = lo_e;
      pk_v_n = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt = f_cnt;
    if (push && !pop)
      cnt_nxt = f_cnt + 1'b1;
    else if (!push && pop)
      cnt_nxt = f_cnt - 1'b1;
  end

  assign wait_n = (cnt_nxt >= WAIT_TH) || pd_v_n
               || (pk_v_n && !ioctl_downl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pk_v       <= 1'b0;
      pk_a       <= '0;
      pk_d       <= '0;
      pd_v       <= 1'b0;
      pd_e       <= '0;
      ioctl_wait <= 1'b0;
      downl_q    <= 1'b0;
    end else begin
      pk_v       <= pk_v_n;
      pk_a       <= pk_a_n;
      pk_d       <= pk_d_n;
      pd_v       <= pd_v_n;
      pd_e       <= pd_e_n;
      ioctl_wait <= wait_n;
      downl_q    <= ioctl_downl;
    end
  end

  ldr_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_e),
    .pop   (pop),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sdr.port_req <= 1'b0;
      sdr.port_a   <= '0;
      sdr.port_ds  <= 2'b00;
      sdr.port_d   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (pop) begin
          sdr.port_a   <= head.addr + BASE_ADDR;
          sdr.port_ds  <= head.ds;
          sdr.port_d   <= head.d;
          sdr.port_req <= ~sdr.port_req;
          state        <= ST_WAIT;
        end
        ST_WAIT: if (sdr.port_ack == sdr.port_req)
          state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rom_ready <= 1'b0;
    else if (ioctl_downl && !downl_q)
      rom_ready <= 1'b0;
    else if (!ioctl_downl && !pk_v && !pd_v && f_empty
             && state == ST_IDLE
             && sdr.port_ack == sdr.port_req)
      rom_ready <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_rom_loader.sv
// tb_sdram_rom_loader: download streams checked against a queue-level
// model of the byte-to-word packing rules, with a delayed-ack controller.
`timescale 1ns/1ps
module tb_sdram_rom_loader;

  localparam logic [22:0] BASE = 23'h200000;

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        rom_ready;

  sdram_rom_loader_if sdr();

  sdram_rom_loader #(
    .FIFO_AW   (2),
    .BASE_ADDR (BASE),
    .ADDR_W    (25)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wait  (ioctl_wait),
    .rom_ready   (rom_ready),
    .sdr         (sdr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mask(logic [1:0] ds);
    return {{8{ds[1]}}, {8{ds[0]}}};
  endfunction

  // controller: latch each toggle, hold ack back ack_dly cycles
  wr_t obs_q[$];
  wr_t cap;
  int  ack_dly = 2;
  int  cnt = 0;
  bit  busy = 0;

  always @(negedge clk) begin
    if (reset) begin
      sdr.port_ack = 1'b0;
      busy = 0;
    end else if (busy) begin
      chk("stable", {sdr.port_a, sdr.port_ds, sdr.port_d},
          {cap.a, cap.ds, cap.d});
      if (cnt == 0) begin
        sdr.port_ack = sdr.port_req;
        busy = 0;
      end else begin
        cnt--;
      end
    end else if (sdr.port_req != sdr.port_ack) begin
      wr_t w;
      cap.a  = sdr.port_a;
      cap.ds = sdr.port_ds;
      cap.d  = sdr.port_d;
      w = cap;
      w.d = cap.d & mask(cap.ds);
      obs_q.push_back(w);
      busy = 1;
      cnt = ack_dly;
    end
  end

  always @(posedge clk) begin
    if (!reset && ioctl_wr && ioctl_wait)
      $error("protocol: ioctl_wr while ioctl_wait");
  end

  // reference model: word = byte_addr / 2, offset by BASE, 23-bit wrap
  wr_t         exp_q[$];
  bit          m_pv = 0;
  logic [24:0] m_pa = '0;
  logic [7:0]  m_pd = '0;

  function automatic void emit(logic [24:0] ba, logic [1:0] ds,
                               logic [15:0] d);
    wr_t w;
    w.a  = 23'((ba >> 1) + 25'(BASE));
    w.ds = ds;
    w.d  = d & mask(ds);
    exp_q.push_back(w);
  endfunction

  function automatic void model_byte(logic [24:0] a, logic [7:0] d);
    if (!a[0]) begin
      if (m_pv) emit(m_pa, 2'b01, {8'h00, m_pd});
      m_pv = 1;
      m_pa = a;
      m_pd = d;
    end else if (m_pv && (m_pa >> 1) == (a >> 1)) begin
      emit(a, 2'b11, {d, m_pd});
      m_pv = 0;
    end else begin
      if (m_pv) emit(m_pa, 2'b01, {8'h00, m_pd});
      m_pv = 0;
      emit(a, 2'b10, {d, 8'h00});
    end
  endfunction

  function automatic wr_t get_obs(int i);
    wr_t o;
    o.a = '1; o.ds = '1; o.d = '1;
    if (i < obs_q.size()) o = obs_q[i];
    return o;
  endfunction

  task automatic send(logic [24:0] a, logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ok", ioctl_wait, 0);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    model_byte(a, d);
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  logic [24:0] st_a[$];
  logic [7:0]  st_d[$];

  task automatic run_dl(string tag, bit watch);
    int n = 0;
    bit seen = 0;
    exp_q.delete();
    obs_q.delete();
    m_pv = 0;
    ioctl_downl = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy0"}, rom_ready, 0);
    foreach (st_a[i]) begin
      if (watch && !seen && ioctl_wait) begin
        seen = 1;
        chk("wait_rise", i, 8);
      end
      if (!watch && $urandom_range(0, 3) == 0) @(negedge clk);
      send(st_a[i], st_d[i]);
    end
    if (watch) chk("wait_seen", seen, 1);
    ioctl_downl = 1'b0;
    if (m_pv) emit(m_pa, 2'b01, {8'h00, m_pd});
    m_pv = 0;
    while (!rom_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, rom_ready, 1);
    chk({tag, "_cnt"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      wr_t o;
      o = get_obs(i);
      chk(tag, {o.a, o.ds, o.d}, {exp_q[i].a, exp_q[i].ds, exp_q[i].d});
    end
  endtask

  task automatic chk_obs(string tag, int i, logic [22:0] a,
                         logic [1:0] ds, logic [15:0] d);
    wr_t o;
    o = get_obs(i);
    chk(tag, {o.a, o.ds, o.d}, {a, ds, d});
  endtask

  task automatic load(logic [24:0] a, logic [7:0] d);
    st_a.push_back(a);
    st_d.push_back(d);
  endtask

  initial begin
    int n;
    logic [24:0] start;
    bit seq;

    repeat (3) @(negedge clk);
    chk("rst_req", sdr.port_req, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_a", sdr.port_a, 0);
    chk("rst_ds", sdr.port_ds, 0);
    chk("rst_d", sdr.port_d, 0);
    chk("rst_rdy", rom_ready, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    st_a.delete(); st_d.delete();
    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
    run_dl("seq4", 0);
    chk_obs("seq4_w0", 0, BASE, 2'b11, 16'h2211);
    chk_obs("seq4_w1", 1, BASE + 23'd1, 2'b11, 16'h4433);

    st_a.delete(); st_d.delete();
    load(0, 8'hAA); load(1, 8'hBB); load(2, 8'hCC);
    run_dl("odd3", 0);
    chk_obs("odd3_w1", 1, BASE + 23'd1, 2'b01, 16'h00CC);

    st_a.delete(); st_d.delete();
    load(25'h10, 8'h5A); load(25'h11, 8'hA5);
    run_dl("base", 0);
    chk_obs("base_w0", 0, 23'h200008, 2'b11, 16'hA55A);

    st_a.delete(); st_d.delete();
    load(25'h0C00000, 8'h01); load(25'h0C00001, 8'h02);
    run_dl("wrap", 0);
    chk_obs("wrap_w0", 0, 23'h000000, 2'b11, 16'h0201);

    st_a.delete(); st_d.delete();
    load(25'h05, 8'h77); load(25'h04, 8'h66);
    run_dl("nseq", 0);
    chk_obs("nseq_w0", 0, BASE + 23'd2, 2'b10, 16'h7700);
    chk_obs("nseq_w1", 1, BASE + 23'd2, 2'b01, 16'h0066);

    ack_dly = 40;
    st_a.delete(); st_d.delete();
    for (int k = 0; k < 24; k++)
      load(25'h100 + 25'(k), 8'($urandom));
    run_dl("burst", 1);

    for (int r = 0; r < 8; r++) begin
      ack_dly = $urandom_range(0, 12);
      st_a.delete(); st_d.delete();
      start = 25'($urandom);
      seq = $urandom_range(0, 1) == 1;
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++)
        load(seq ? start + 25'(k) : start + 25'($urandom_range(0, 7)),
             8'($urandom));
      run_dl("rand", 0);
    end

    obs_q.delete();
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h20;
    ioctl_dout = 8'h99;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_wr_cnt", obs_q.size(), 0);
    chk("idle_wr_rdy", rom_ready, 1);

    ack_dly = 30;
    obs_q.delete();
    ioctl_downl = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(25'h40 + 25'(k), 8'(k + 1));
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_inwait", busy, 1);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    @(negedge clk);
    chk("mrst_req", sdr.port_req, 0);
    chk("mrst_rdy", rom_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    repeat (10) @(negedge clk);
    chk("mrst_empty", obs_q.size(), 0);

    ack_dly = 3;
    st_a.delete(); st_d.delete();
    for (int k = 0; k < 8; k++) load(25'h40 + 25'(k), 8'(k + 1));
    run_dl("replay", 0);
    chk_obs("replay_w0", 0, BASE + 23'h20, 2'b11, 16'h0201);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_rom_loader.md
Name: sdram_rom_loader

Overview:
- Upstream feeder for the SDRAM controller's general-purpose request port.
- Converts the byte-serial ROM download stream from the I/O controller into 16-bit SDRAM writes.
- Buffers packed words in a small FIFO and issues them over the toggle req/ack handshake.
- Holds the core in reset until every downloaded byte is committed to SDRAM.

Parameters:
- FIFO_AW, 2, log2 of word-FIFO depth (4 entries).
- BASE_ADDR, 23'h000000, word address added to every write (23 bits, [23:1]).
- ADDR_W, 25, width of ioctl_addr in bytes.

Ports:
- clk  in  1  SDRAM clock; same clock as the controller.
- reset  in  1  asynchronous, active-high.
- ioctl_downl  in  1  download active.
- ioctl_wr  in  1  one-cycle strobe; byte valid.
- ioctl_addr  in  ADDR_W  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  backpressure to the I/O controller; no ioctl_wr accepted while high.
- port_req  out  1  toggle request to the controller.
- port_ack  in  1  controller echoes port_req when the write is issued.
- port_we  out  1  constant 1.
- port_a  out  23  word address [23:1].
- port_ds  out  2  byte enables; [1] is the high byte, [0] the low byte.
- port_d  out  16  write data.
- rom_ready  out  1  all download data committed; core may leave reset.

Behaviour:
- Reset values: ioctl_wait=0, port_req=0, port_a=0, port_ds=2'b00, port_d=0, rom_ready=0, FIFO empty, pack register empty, FSM=IDLE.
- Byte packing, on ioctl_wr while ioctl_downl=1:
  - Even ioctl_addr: byte goes to the pack low half (ds bit0). Word address = ioctl_addr[ADDR_W-1:1].
  - Odd ioctl_addr with a matching pending even byte: byte goes to the high half. Push {addr, data, ds=2'b11} into the FIFO the same cycle.
  - Odd byte with no pending even byte, or with a different word address: push the pending even byte alone (ds=2'b01) if present, then push the odd byte alone (ds=2'b10).
  - Even byte arriving while an even byte is pending: push the pending one (ds=2'b01) first.
  - One push per cycle. A case needing two pushes takes two cycles; ioctl_wait is forced high for the second.
- Flush: on ioctl_downl falling edge, push any pending even byte with ds=2'b01.
- ioctl_wait = FIFO count >= depth-1, OR a two-push or flush is in progress. Registered.
- ioctl_wr while ioctl_wait=1 is a protocol violation; the byte is dropped. Assertion in the bench.
- FSM, one transaction outstanding at a time:
  - IDLE: if FIFO not empty, pop the head, load port_a = entry.addr + BASE_ADDR (23-bit wrap, carry discarded), load port_ds and port_d, toggle port_req, go to WAIT.
  - WAIT: when port_ack == port_req, go to IDLE.
  - Minimum 3 cycles per word, bounded by controller latency (7-cycle slot).
  - port_a, port_ds and port_d stay stable from the toggle until the ack.
- rom_ready:
  - Cleared on ioctl_downl rising edge.
  - Set when ioctl_downl=0 AND pack register empty AND FIFO empty AND FSM=IDLE AND port_ack==port_req.
  - Sticky until the next download.
- New download start while writes are still in flight: the FSM completes the pending transaction. FIFO contents are kept, not discarded.
- Reset mid-transaction: port_req returns to 0. The controller's latched state may differ, so the system resets both blocks together (same reset net). Not handled internally.
- ioctl_wr with ioctl_downl=0: ignored.

Decomposition:
- Shared package sdram_ldr_pkg:
  - Typedef ldr_entry_t {logic [22:0] addr; logic [1:0] ds; logic [15:0] d;}.
  - Constant DS_LO=2'b01, DS_HI=2'b10, DS_W=2'b11.
  - FSM enum {S_IDLE, S_WAIT}.
- One sub-module: ldr_fifo. Synchronous, parameterised depth. Registered count, full/empty flags, first-word fall-through head. Packing logic and FSM stay in the top.

Test Plan:
- Bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3, then downl falls -> two writes: a=0 d=16'h2211 ds=11; a=1 d=16'h4433 ds=11. rom_ready=1 after the second ack.
- Odd-length stream 0xAA@0, 0xBB@1, 0xCC@2, downl falls -> second write a=1 ds=01 d[7:0]=0xCC.
- BASE_ADDR=23'h200000, byte pair @ byte address 0x10 -> port_a=23'h200008.
- Controller ack delayed 40 cycles, burst of 12 back-to-back byte pairs:
  - ioctl_wait rises when 3 entries are queued.
  - No byte is lost; writes appear in address order.
  - port_a/d/ds are stable during every WAIT.
- Non-sequential addresses 0x05 then 0x04 -> two single-byte writes: a=2 ds=10 first, then a=2 ds=01.
- Assert reset during WAIT, then restart the download -> port_req=0, rom_ready=0, FIFO empty. The replayed stream produces the correct writes.
